// File: rtl/oric_tap_loader.sv
// Oric .TAP loader: parses a TAP image from the mist_io ioctl bus and writes its data bytes into RAM.
// Optional ORIC_TAP_MULTIBLOCK_EN: keep loading blocks until the download ends; results come from block 1.
module oric_tap_loader #(
    parameter logic [7:0] TAP_INDEX  = 8'd1,
    parameter int         FIFO_DEPTH = 4,
    parameter int         MAX_NAME   = 16
) (
    input  logic        clk_24,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_dout,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_dout,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic        autorun,
    output logic        is_basic,
    output logic [15:0] exec_addr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int NW = $clog2(MAX_NAME + 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SYNC  = 3'd1;
    localparam logic [2:0] ST_HDR   = 3'd2;
    localparam logic [2:0] ST_NAME  = 3'd3;
    localparam logic [2:0] ST_DATA  = 3'd4;
    localparam logic [2:0] ST_DRAIN = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;
    localparam logic [2:0] ST_ERR   = 3'd7;

    logic [2:0]    state, state_n;
    logic          wr_prev, dl_prev;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_cnt;
    logic [1:0]    sync_cnt;
    logic [3:0]    hdr_idx;
    logic [NW-1:0] name_cnt;
    logic [7:0]    hdr_type, hdr_auto;
    logic [15:0]   hdr_start, hdr_end, offset;
    logic [16:0]   remaining;
    logic          first_valid, block_done;
    logic [7:0]    first_type, first_auto;
    logic [15:0]   first_start;

    logic       fifo_empty, fifo_full, start, capture, parse_pop, ack_pop, pop, push, overflow;
    logic       truncated, flush;
    logic [7:0] head;

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == CW'(FIFO_DEPTH));
    assign head       = fifo_mem[rd_ptr];
    assign start      = (state == ST_IDLE) && ioctl_download && !dl_prev && (ioctl_index == TAP_INDEX);
    assign capture    = ioctl_wr && !wr_prev && ioctl_download && (ioctl_index == TAP_INDEX)
                        && (state != ST_ERR) && (state != ST_DONE) && ((state != ST_IDLE) || start);
    assign parse_pop  = (state inside {ST_SYNC, ST_HDR, ST_NAME, ST_DRAIN}) && !fifo_empty;
    assign ack_pop    = (state == ST_DATA) && mem_req && mem_ack;
    assign pop        = parse_pop || ack_pop;
    // A full FIFO only overflows if nothing leaves it in the same cycle.
    assign overflow   = capture && fifo_full && !pop;
    assign push       = capture && !overflow;
    assign truncated  = !ioctl_download && fifo_empty;
    assign flush      = (state == ST_ERR) || (state == ST_DONE) || ((state == ST_IDLE) && !start);

    assign cpu_hold = state inside {ST_SYNC, ST_HDR, ST_NAME, ST_DATA, ST_DRAIN};
    assign done     = (state == ST_DONE);

    always_comb begin
        // NOTE: state_n gets a default first so every path assigns it and no latch is inferred.
        state_n = state;
        case (state)
            ST_IDLE: if (start) state_n = ST_SYNC;
            ST_SYNC: begin
                if (!fifo_empty) begin
                    if (head == 8'h24 && sync_cnt == 2'd3) state_n = ST_HDR;
                end else if (truncated) begin
                    state_n = block_done ? ST_DRAIN : ST_ERR;
                end
            end
            ST_HDR: begin
                if (!fifo_empty) begin
                    if (hdr_idx == 4'd8) state_n = (hdr_start > hdr_end) ? ST_ERR : ST_NAME;
                end else if (truncated) begin
                    state_n = ST_ERR;
                end
            end
            ST_NAME: begin
                if (!fifo_empty) begin
                    if (head == 8'h00) state_n = ST_DATA;
                    else if (name_cnt == NW'(MAX_NAME - 1)) state_n = ST_ERR;
                end else if (truncated) begin
                    state_n = ST_ERR;
                end
            end
            ST_DATA: begin
                if (ack_pop && remaining == 17'd1) begin
`ifdef ORIC_TAP_MULTIBLOCK_EN
                    state_n = ioctl_download ? ST_SYNC : ST_DRAIN;
`else
                    state_n = ST_DRAIN;
`endif
                end else if (truncated) begin
                    state_n = ST_ERR;
                end
            end
            ST_DRAIN: if (!ioctl_download) state_n = ST_DONE;
            ST_DONE:  state_n = ST_IDLE;
            ST_ERR:   if (!ioctl_download) state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
        if (overflow) state_n = ST_ERR;
    end

    // NOTE: the byte store has no reset; fifo_cnt alone decides which entries are meaningful.
    always_ff @(posedge clk_24) begin
        if (push) fifo_mem[wr_ptr] <= ioctl_dout;
    end

    // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_24) begin
        if (reset) begin
            state       <= ST_IDLE;
            wr_prev     <= 1'b0;
            dl_prev     <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            sync_cnt    <= 2'd0;
            hdr_idx     <= 4'd0;
            name_cnt    <= '0;
            hdr_type    <= 8'h00;
            hdr_auto    <= 8'h00;
            hdr_start   <= 16'h0000;
            hdr_end     <= 16'h0000;
            offset      <= 16'h0000;
            remaining   <= 17'd0;
            first_valid <= 1'b0;
            block_done  <= 1'b0;
            first_type  <= 8'h00;
            first_auto  <= 8'h00;
            first_start <= 16'h0000;
            mem_req     <= 1'b0;
            mem_addr    <= 16'h0000;
            mem_dout    <= 8'h00;
            error       <= 1'b0;
            autorun     <= 1'b0;
            is_basic    <= 1'b0;
            exec_addr   <= 16'h0000;
        end else begin
            state   <= state_n;
            wr_prev <= ioctl_wr;
            dl_prev <= ioctl_download;

            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fifo_cnt <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
            end

            if (start) begin
                error       <= 1'b0;
                sync_cnt    <= 2'd0;
                first_valid <= 1'b0;
                block_done  <= 1'b0;
            end else if (state_n == ST_ERR) begin
                error <= 1'b1;
            end

            case (state)
                ST_SYNC: if (!fifo_empty) begin
                    if (head == 8'h16) begin
                        if (sync_cnt != 2'd3) sync_cnt <= sync_cnt + 2'd1;
                    end else begin
                        sync_cnt <= 2'd0;
                        hdr_idx  <= 4'd0;
                    end
                end
                ST_HDR: if (!fifo_empty) begin
                    hdr_idx <= hdr_idx + 4'd1;
                    case (hdr_idx)
                        4'd2: hdr_type        <= head;
                        4'd3: hdr_auto        <= head;
                        4'd4: hdr_end[15:8]   <= head;
                        4'd5: hdr_end[7:0]    <= head;
                        4'd6: hdr_start[15:8] <= head;
                        4'd7: hdr_start[7:0]  <= head;
                        4'd8: begin
                            remaining <= {1'b0, hdr_end} - {1'b0, hdr_start} + 17'd1;
                            offset    <= 16'h0000;
                            name_cnt  <= '0;
                            if (!first_valid) begin
                                first_valid <= 1'b1;
                                first_type  <= hdr_type;
                                first_auto  <= hdr_auto;
                                first_start <= hdr_start;
                            end
                        end
                        default: ;
                    endcase
                end
                ST_NAME: if (!fifo_empty && head != 8'h00) name_cnt <= name_cnt + NW'(1);
                ST_DATA: if (ack_pop) begin
                    offset    <= offset + 16'd1;
                    remaining <= remaining - 17'd1;
                    if (remaining == 17'd1) begin
                        block_done <= 1'b1;
                        sync_cnt   <= 2'd0;
                    end
                end
                ST_DRAIN: if (state_n == ST_DONE) begin
                    autorun   <= (first_auto != 8'h00);
                    is_basic  <= (first_type == 8'h00);
                    exec_addr <= first_start;
                end
                default: ;
            endcase

            // One request per FIFO head; mem_req drops on ack and re-arms no sooner than the next cycle.
            if (state == ST_DATA && state_n == ST_DATA) begin
                if (ack_pop) begin
                    mem_req <= 1'b0;
                end else if (!mem_req && !fifo_empty) begin
                    mem_req  <= 1'b1;
                    mem_addr <= hdr_start + offset;
                    mem_dout <= head;
                end
            end else begin
                mem_req <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_oric_tap_loader.sv
// Self-checking bench for oric_tap_loader: scoreboarded RAM writes plus per-scenario result checks.
// Build with ORIC_TAP_MULTIBLOCK_EN defined to check the multi-block expectations.
module tb_oric_tap_loader;
    logic        clk_24 = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [7:0]  ioctl_dout;
    logic        mem_req;
    logic        mem_ack;
    logic [15:0] mem_addr;
    logic [7:0]  mem_dout;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic        autorun;
    logic        is_basic;
    logic [15:0] exec_addr;

    oric_tap_loader dut (
        .clk_24         (clk_24),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_dout     (ioctl_dout),
        .mem_req        (mem_req),
        .mem_ack        (mem_ack),
        .mem_addr       (mem_addr),
        .mem_dout       (mem_dout),
        .cpu_hold       (cpu_hold),
        .done           (done),
        .error          (error),
        .autorun        (autorun),
        .is_basic       (is_basic),
        .exec_addr      (exec_addr)
    );

    always #5 clk_24 = ~clk_24;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [23:0] exp_q[$];
    int          ack_delay    = 0;
    bit          ack_block    = 1'b0;
    int          write_count  = 0;
    int          done_count   = 0;
    int          req_count    = 0;

    // RAM-side responder: acks requests after ack_delay cycles and scores each write against exp_q.
    initial begin : responder
        int          age;
        logic        req_prev;
        logic [23:0] e;
        age      = 0;
        req_prev = 1'b0;
        mem_ack  = 1'b0;
        forever begin
            @(negedge clk_24);
            mem_ack = 1'b0;
            if (done === 1'b1) done_count++;
            if (mem_req === 1'b1 && !req_prev) req_count++;
            req_prev = (mem_req === 1'b1);
            if (mem_req === 1'b1 && !ack_block) begin
                if (age >= ack_delay) begin
                    mem_ack = 1'b1;
                    age     = 0;
                    write_count++;
                    tests_run++;
                    if (exp_q.size() == 0) begin
                        tests_failed++;
                        $display("FAIL write_unexpected: got %h=%h, required no write", mem_addr, mem_dout);
                    end else begin
                        e = exp_q.pop_front();
                        if ({mem_addr, mem_dout} !== e)
                        begin
                            tests_failed++;
                            $display("FAIL write_order: got %h=%h, required %h=%h", mem_addr, mem_dout, e[23:8], e[7:0]);
                        end
                    end
                end else begin
                    age++;
                end
            end else begin
                age = 0;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_24);
    endtask

    task automatic send_byte(input logic [7:0] b);
        ioctl_dout = b;
        ioctl_wr   = 1'b1;
        tick(2);
        ioctl_wr   = 1'b0;
        tick(2);
    endtask

    task automatic start_dl();
        ioctl_index    = 8'd1;
        ioctl_download = 1'b1;
        tick(2);
    endtask

    task automatic send_header(input logic [7:0] typ, input logic [7:0] aut,
                               input logic [15:0] st, input logic [15:0] en);
        logic [7:0] hdr [15];
        hdr = '{8'h16, 8'h16, 8'h16, 8'h24, 8'h00, 8'h00, typ, aut,
                en[15:8], en[7:0], st[15:8], st[7:0], 8'h00, 8'h41, 8'h00};
        for (int i = 0; i < 15; i++) send_byte(hdr[i]);
    endtask

    task automatic send_data(input logic [15:0] st, input int n, input logic [7:0] seed, input bit expect_it);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = seed + 8'(i);
            if (expect_it) exp_q.push_back({st + 16'(i), b});
            send_byte(b);
        end
    endtask

    task automatic wait_release(input int limit, input string name);
        int n;
        n = 0;
        while (cpu_hold === 1'b1 && n < limit) begin
            tick(1);
            n++;
        end
        tests_run++;
        if (cpu_hold !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_timeout: cpu_hold=%b after %0d cycles, required 0", name, cpu_hold, limit);
        end
        tick(3);
    endtask

    task automatic test_reset();
        reset = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0; ioctl_dout = 8'h00;
        tick(3);
        reset = 1'b0;
        tick(2);
        tests_run++;
        if ({mem_req, cpu_hold, done, error, autorun, is_basic} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got req/hold/done/err/auto/basic=%b, required 000000",
                     {mem_req, cpu_hold, done, error, autorun, is_basic});
        end
        tests_run++;
        if (exec_addr !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_exec: got %h, required 0000", exec_addr);
        end
    endtask

    task automatic test_single();
        int d0, w0;
        d0 = done_count; w0 = write_count;
        ack_delay = 0;
        start_dl();
        tests_run++;
        if (cpu_hold !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_hold: got %b, required 1", cpu_hold);
        end
        send_header(8'h80, 8'hC7, 16'h0500, 16'h0500);
        send_data(16'h0500, 1, 8'hAA, 1'b1);
        ioctl_download = 1'b0;
        wait_release(100, "single");
        tests_run++;
        if (done_count - d0 !== 1) begin
            tests_failed++;
            $display("FAIL single_done: got %0d pulses, required 1", done_count - d0);
        end
        tests_run++;
        if (write_count - w0 !== 1) begin
            tests_failed++;
            $display("FAIL single_writes: got %0d, required 1", write_count - w0);
        end
        tests_run++;
        if ({error, autorun, is_basic} !== 3'b010) begin
            tests_failed++;
            $display("FAIL single_flags: got err/auto/basic=%b, required 010", {error, autorun, is_basic});
        end
        tests_run++;
        if (exec_addr !== 16'h0500) begin
            tests_failed++;
            $display("FAIL single_exec: got %h, required 0500", exec_addr);
        end
    endtask

    task automatic test_delayed_ack();
        int d0, w0;
        d0 = done_count; w0 = write_count;
        ack_delay = 5;
        start_dl();
        send_header(8'h00, 8'h00, 16'h0501, 16'h0504);
        send_data(16'h0501, 4, 8'h11, 1'b1);
        ioctl_download = 1'b0;
        wait_release(300, "delayed");
        ack_delay = 0;
        tests_run++;
        if (write_count - w0 !== 4 || error !== 1'b0) begin
            tests_failed++;
            $display("FAIL delayed_writes: got %0d writes err=%b, required 4 writes err=0", write_count - w0, error);
        end
        tests_run++;
        if (done_count - d0 !== 1 || {autorun, is_basic} !== 2'b01 || exec_addr !== 16'h0501) begin
            tests_failed++;
            $display("FAIL delayed_result: got done=%0d auto/basic=%b exec=%h, required 1 01 0501",
                     done_count - d0, {autorun, is_basic}, exec_addr);
        end
    endtask

    task automatic test_bad_range();
        int r0;
        r0 = req_count;
        start_dl();
        send_header(8'h00, 8'h00, 16'h0600, 16'h05FF);
        wait_release(50, "bad_range");
        tests_run++;
        if (error !== 1'b1) begin
            tests_failed++;
            $display("FAIL bad_range_error: got %b, required 1", error);
        end
        tests_run++;
        if (req_count - r0 !== 0) begin
            tests_failed++;
            $display("FAIL bad_range_reqs: got %0d, required 0", req_count - r0);
        end
        ioctl_download = 1'b0;
        tick(4);
        tests_run++;
        if (error !== 1'b1) begin
            tests_failed++;
            $display("FAIL bad_range_sticky: got %b, required 1", error);
        end
    endtask

    task automatic test_truncated();
        int d0, w0;
        d0 = done_count; w0 = write_count;
        start_dl();
        tests_run++;
        if (error !== 1'b0) begin
            tests_failed++;
            $display("FAIL trunc_clear: got %b, required 0", error);
        end
        send_header(8'h00, 8'h01, 16'h0700, 16'h0703);
        send_data(16'h0700, 2, 8'h21, 1'b1);
        ioctl_download = 1'b0;
        wait_release(100, "trunc");
        tests_run++;
        if (write_count - w0 !== 2 || error !== 1'b1 || done_count !== d0) begin
            tests_failed++;
            $display("FAIL trunc_result: got writes=%0d err=%b done=%0d, required 2 1 0",
                     write_count - w0, error, done_count - d0);
        end
    endtask

    task automatic test_overflow();
        int w0;
        w0 = write_count;
        ack_block = 1'b1;
        start_dl();
        send_header(8'h00, 8'h00, 16'h0700, 16'h07FF);
        send_data(16'h0700, 4, 8'h50, 1'b0);
        tests_run++;
        if (error !== 1'b0 || mem_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow_early: got err=%b req=%b after 19 strobes, required 0 1", error, mem_req);
        end
        send_byte(8'h54);
        tests_run++;
        if ({error, mem_req, cpu_hold} !== 3'b100) begin
            tests_failed++;
            $display("FAIL overflow_push5: got err/req/hold=%b, required 100", {error, mem_req, cpu_hold});
        end
        ioctl_download = 1'b0;
        ack_block = 1'b0;
        tick(6);
        tests_run++;
        if (write_count - w0 !== 0) begin
            tests_failed++;
            $display("FAIL overflow_writes: got %0d, required 0", write_count - w0);
        end
    endtask

    task automatic test_multiblock();
        int d0, w0, exp_writes;
`ifdef ORIC_TAP_MULTIBLOCK_EN
        bit second = 1'b1;
        exp_writes = 3;
`else
        bit second = 1'b0;
        exp_writes = 2;
`endif
        d0 = done_count; w0 = write_count;
        start_dl();
        send_header(8'h00, 8'h00, 16'h0800, 16'h0801);
        send_data(16'h0800, 2, 8'h01, 1'b1);
        send_header(8'h80, 8'h01, 16'h0900, 16'h0900);
        send_data(16'h0900, 1, 8'h30, second);
        ioctl_download = 1'b0;
        wait_release(100, "multi");
        tests_run++;
        if (write_count - w0 !== exp_writes || error !== 1'b0) begin
            tests_failed++;
            $display("FAIL multi_writes: got %0d err=%b, required %0d err=0", write_count - w0, error, exp_writes);
        end
        tests_run++;
        if (done_count - d0 !== 1 || exec_addr !== 16'h0800 || {autorun, is_basic} !== 2'b01) begin
            tests_failed++;
            $display("FAIL multi_result: got done=%0d exec=%h auto/basic=%b, required 1 0800 01",
                     done_count - d0, exec_addr, {autorun, is_basic});
        end
    endtask

    task automatic test_reset_mid_data();
        int r0;
        ack_block = 1'b1;
        start_dl();
        send_header(8'h00, 8'h00, 16'h0A00, 16'h0A0F);
        send_data(16'h0A00, 2, 8'h60, 1'b0);
        tests_run++;
        if ({mem_req, cpu_hold} !== 2'b11) begin
            tests_failed++;
            $display("FAIL midreset_pre: got req/hold=%b, required 11", {mem_req, cpu_hold});
        end
        reset = 1'b1;
        ioctl_download = 1'b0;
        tick(1);
        tests_run++;
        if ({mem_req, cpu_hold, error} !== 3'b000 || dut.fifo_cnt !== '0) begin
            tests_failed++;
            $display("FAIL midreset_post: got req/hold/err=%b fifo=%0d, required 000 0",
                     {mem_req, cpu_hold, error}, dut.fifo_cnt);
        end
        reset = 1'b0;
        ack_block = 1'b0;
        r0 = req_count;
        tick(10);
        tests_run++;
        if (req_count - r0 !== 0 || mem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_quiet: got %0d new reqs, required 0", req_count - r0);
        end
    endtask

    initial begin : main
        test_reset();
        test_single();
        test_delayed_ack();
        test_bad_range();
        test_truncated();
        test_overflow();
        test_multiblock();
        test_reset_mid_data();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d writes outstanding, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
